// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle execution-stage ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_AND = 4'b0001,
    ALU_OR  = 4'b0010,
    ALU_SLL = 4'b0011,
    ALU_SLT = 4'b0100,
    ALU_SRL = 4'b0101,
    ALU_SUB = 4'b0110,
    ALU_XOR = 4'b0111,
    ALU_BEQ = 4'b1000,
    ALU_BNE = 4'b1001,
    ALU_BLT = 4'b1010,
    ALU_BGE = 4'b1011
  } alu_sel_t;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_t;

endpackage

// File: rtl/alu_desplazador.sv
// Combinational single-step shifter: logical left (dir=0) or right (dir=1), zero fill.
module alu_desplazador #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
) (
  input  logic             dir,
  input  logic [WIDTH-1:0] data,
  input  logic [AW-1:0]    amount,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = dir ? (data >> amount) : (data << amount);
  end

endmodule

// File: rtl/alu_multiciclo.sv
// Execution-stage ALU: single-cycle logic/arith/compare/branch ops, iterative SLL/SRL,
// valid/ready handshake on request and result sides.
module alu_multiciclo
  import alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [3:0]       ALUSELECT,
  input  logic [WIDTH-1:0] OPA,
  input  logic [WIDTH-1:0] OPB,
  output logic [WIDTH-1:0] RES,
  output logic             ZERO,
  output logic             TAKEN,
  output logic             OUT_VALID,
  input  logic             OUT_READY
);

  localparam int SW = $clog2(WIDTH);
  localparam logic [SW:0] STEP = (SW+1)'(SHIFT_STEP);

  state_t           state;
  logic [WIDTH-1:0] data;
  logic [SW-1:0]    rem;
  logic             dir;

  logic [SW-1:0]    shamt_in;
  logic [SW-1:0]    step;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] op_res;
  logic             op_taken;
  logic             is_shift;

  assign shamt_in  = OPB[SW-1:0];
  assign IN_READY  = (state == IDLE);
  assign OUT_VALID = (state == DONE);

  // Never shift past the remaining amount so the last step lands exactly on shamt.
  always_comb begin
    step = rem;
    if ({1'b0, rem} > STEP) step = STEP[SW-1:0];
  end

  alu_desplazador #(
    .WIDTH(WIDTH),
    .AW   (SW)
  ) u_desplazador (
    .dir   (dir),
    .data  (data),
    .amount(step),
    .result(shifted)
  );

  // Shifts only take this path when shamt==0, where the result is OPA unchanged.
  always_comb begin
    op_res   = '0;
    op_taken = 1'b0;
    is_shift = 1'b0;
    case (alu_sel_t'(ALUSELECT))
      ALU_ADD: op_res = OPA + OPB;
      ALU_AND: op_res = OPA & OPB;
      ALU_OR:  op_res = OPA | OPB;
      ALU_XOR: op_res = OPA ^ OPB;
      ALU_SUB: op_res = OPA - OPB;
      ALU_SLT: op_res = {{(WIDTH-1){1'b0}}, ($signed(OPA) < $signed(OPB))};
      ALU_SLL, ALU_SRL: begin
        is_shift = 1'b1;
        op_res   = OPA;
      end
      ALU_BEQ: op_taken = (OPA == OPB);
      ALU_BNE: op_taken = (OPA != OPB);
      ALU_BLT: op_taken = ($signed(OPA) < $signed(OPB));
      ALU_BGE: op_taken = ($signed(OPA) >= $signed(OPB));
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state <= IDLE;
      data  <= '0;
      rem   <= '0;
      dir   <= 1'b0;
      RES   <= '0;
      ZERO  <= 1'b0;
      TAKEN <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (IN_VALID) begin
            if (is_shift && (shamt_in != '0)) begin
              data  <= OPA;
              rem   <= shamt_in;
              dir   <= (ALUSELECT == ALU_SRL);
              state <= EXEC;
            end else begin
              RES   <= op_res;
              ZERO  <= (op_res == '0);
              TAKEN <= op_taken;
              state <= DONE;
            end
          end
        end
        EXEC: begin
          data <= shifted;
          rem  <= rem - step;
          if (rem == step) begin
            RES   <= shifted;
            ZERO  <= (shifted == '0);
            TAKEN <= 1'b0;
            state <= DONE;
          end
        end
        DONE: begin
          if (OUT_READY) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multiciclo.sv
// Bench for alu_multiciclo: two instances (SHIFT_STEP 1 and 4) share stimulus; expectations via scoreboard.
module tb_alu_multiciclo;

  typedef struct {
    logic [3:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        zero;
    logic        taken;
    int unsigned lat1;
    int unsigned lat4;
  } vec_t;

  logic        CLK = 1'b0;
  logic        RST_n = 1'b0;
  logic        IN_VALID = 1'b0;
  logic [3:0]  ALUSELECT = '0;
  logic [31:0] OPA = '0;
  logic [31:0] OPB = '0;
  logic        OUT_READY = 1'b0;

  logic        in_ready1, zero1, taken1, out_valid1;
  logic [31:0] res1;
  logic        in_ready4, zero4, taken4, out_valid4;
  logic [31:0] res4;

  int unsigned errors = 0;
  int unsigned checks = 0;
  vec_t        sb[$];
  vec_t        tbl[$];

  always #5 CLK = ~CLK;

  alu_multiciclo #(.WIDTH(32), .SHIFT_STEP(1)) u_dut1 (
    .CLK(CLK), .RST_n(RST_n), .IN_VALID(IN_VALID), .IN_READY(in_ready1),
    .ALUSELECT(ALUSELECT), .OPA(OPA), .OPB(OPB), .RES(res1), .ZERO(zero1),
    .TAKEN(taken1), .OUT_VALID(out_valid1), .OUT_READY(OUT_READY)
  );

  alu_multiciclo #(.WIDTH(32), .SHIFT_STEP(4)) u_dut4 (
    .CLK(CLK), .RST_n(RST_n), .IN_VALID(IN_VALID), .IN_READY(in_ready4),
    .ALUSELECT(ALUSELECT), .OPA(OPA), .OPB(OPB), .RES(res4), .ZERO(zero4),
    .TAKEN(taken4), .OUT_VALID(out_valid4), .OUT_READY(OUT_READY)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int unsigned lat_of(input logic [3:0] sel, input logic [4:0] sh,
                                         input int unsigned step);
    if ((sel == 4'd3 || sel == 4'd5) && sh != 5'd0)
      return 1 + (int'(sh) + step - 1) / step;
    return 1;
  endfunction

  function automatic vec_t mk(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] res, input logic zero, input logic taken,
                              input int unsigned lat1, input int unsigned lat4);
    vec_t v;
    v.sel = sel; v.a = a; v.b = b; v.res = res; v.zero = zero; v.taken = taken;
    v.lat1 = lat1; v.lat4 = lat4;
    return v;
  endfunction

  function automatic vec_t model(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
    vec_t v;
    logic [4:0] sh;
    sh = b[4:0];
    v.sel = sel; v.a = a; v.b = b; v.res = '0; v.taken = 1'b0;
    case (sel)
      4'd0:  v.res = a + b;
      4'd1:  v.res = a & b;
      4'd2:  v.res = a | b;
      4'd3:  v.res = a << sh;
      4'd4:  v.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd5:  v.res = a >> sh;
      4'd6:  v.res = a - b;
      4'd7:  v.res = a ^ b;
      4'd8:  v.taken = (a == b);
      4'd9:  v.taken = (a != b);
      4'd10: v.taken = ($signed(a) < $signed(b));
      4'd11: v.taken = ($signed(a) >= $signed(b));
      default: ;
    endcase
    v.zero = (v.res == 32'd0);
    v.lat1 = lat_of(sel, sh, 1);
    v.lat4 = lat_of(sel, sh, 4);
    return v;
  endfunction

  // Called and returns at a negedge; operands are scrambled after accept to test capture.
  task automatic run_op(input vec_t v);
    vec_t e;
    int unsigned cyc, l1, l4;
    bit got1, got4;
    chk("in_ready_before", {in_ready1, in_ready4}, 2'b11);
    ALUSELECT = v.sel; OPA = v.a; OPB = v.b; IN_VALID = 1'b1;
    sb.push_back(v);
    @(negedge CLK);
    IN_VALID = 1'b0; OPA = $urandom; OPB = $urandom; ALUSELECT = 4'($urandom);
    cyc = 1; got1 = 0; got4 = 0; l1 = 0; l4 = 0;
    while (!(got1 && got4) && cyc < 200) begin
      if (out_valid1 && !got1) begin got1 = 1; l1 = cyc; end
      if (out_valid4 && !got4) begin got4 = 1; l4 = cyc; end
      if (!(got1 && got4)) begin @(negedge CLK); cyc++; end
    end
    e = sb.pop_front();
    if (!(got1 && got4)) begin
      chk("out_valid_timeout", {got1, got4}, 2'b11);
    end else begin
      chk("res_s1", res1, e.res);
      chk("zero_s1", zero1, e.zero);
      chk("taken_s1", taken1, e.taken);
      chk("lat_s1", l1, e.lat1);
      chk("res_s4", res4, e.res);
      chk("zero_s4", zero4, e.zero);
      chk("taken_s4", taken4, e.taken);
      chk("lat_s4", l4, e.lat4);
    end
    OUT_READY = 1'b1;
    @(negedge CLK);
    OUT_READY = 1'b0;
    chk("out_valid_after_ack", {out_valid1, out_valid4}, 2'b00);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl.push_back(mk(4'b0000, 32'hFFFFFFFF, 32'h1, 32'h0, 1, 0, 1, 1));
    tbl.push_back(mk(4'b0110, 32'd5, 32'd7, 32'hFFFFFFFE, 0, 0, 1, 1));
    tbl.push_back(mk(4'b0011, 32'h1, 32'd31, 32'h80000000, 0, 0, 32, 9));
    tbl.push_back(mk(4'b0101, 32'hDEADBEEF, 32'd0, 32'hDEADBEEF, 0, 0, 1, 1));
    tbl.push_back(mk(4'b0100, 32'hFFFFFFFF, 32'd1, 32'h1, 0, 0, 1, 1));
    tbl.push_back(mk(4'b0100, 32'h1, 32'hFFFFFFFF, 32'h0, 1, 0, 1, 1));
    tbl.push_back(mk(4'b1011, 32'h80000000, 32'd0, 32'h0, 1, 0, 1, 1));
    tbl.push_back(mk(4'b1000, 32'd7, 32'd7, 32'h0, 1, 1, 1, 1));
    tbl.push_back(mk(4'b1001, 32'd3, 32'd4, 32'h0, 1, 1, 1, 1));
    tbl.push_back(mk(4'b1010, 32'h80000000, 32'd1, 32'h0, 1, 1, 1, 1));
    tbl.push_back(mk(4'b1111, 32'd5, 32'd6, 32'h0, 1, 0, 1, 1));
    tbl.push_back(mk(4'b1100, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 1, 0, 1, 1));
    tbl.push_back(mk(4'b0001, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 0, 0, 1, 1));
    tbl.push_back(mk(4'b0010, 32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0, 0, 0, 1, 1));
    tbl.push_back(mk(4'b0111, 32'hA5A5A5A5, 32'hFFFFFFFF, 32'h5A5A5A5A, 0, 0, 1, 1));
    tbl.push_back(mk(4'b0101, 32'h80000000, 32'h00000023, 32'h10000000, 0, 0, 4, 2));
    tbl.push_back(mk(4'b0011, 32'hFFFFFFFF, 32'd5, 32'hFFFFFFE0, 0, 0, 6, 3));
    tbl.push_back(mk(4'b0101, 32'hFFFFFFFF, 32'd31, 32'h1, 0, 0, 32, 9));

    repeat (2) @(negedge CLK);
    chk("reset_outputs_s1", {res1, zero1, taken1, out_valid1}, '0);
    chk("reset_outputs_s4", {res4, zero4, taken4, out_valid4}, '0);
    RST_n = 1'b1;
    @(negedge CLK);
    chk("in_ready_after_reset", {in_ready1, in_ready4}, 2'b11);

    foreach (tbl[i]) run_op(tbl[i]);

    // Result presented for one cycle when OUT_READY is already high on DONE entry.
    ALUSELECT = 4'b0000; OPA = 32'd2; OPB = 32'd3; IN_VALID = 1'b1; OUT_READY = 1'b1;
    @(negedge CLK);
    IN_VALID = 1'b0;
    chk("early_ready_valid", {out_valid1, out_valid4}, 2'b11);
    chk("early_ready_res", res1, 32'd5);
    @(negedge CLK);
    OUT_READY = 1'b0;
    chk("early_ready_idle", {out_valid1, in_ready1}, 2'b01);

    // Backpressure: result held, request side closed, competing request dropped.
    ALUSELECT = 4'b0000; OPA = 32'd3; OPB = 32'd4; IN_VALID = 1'b1;
    @(negedge CLK);
    OPA = 32'd100; OPB = 32'd200;
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold", {out_valid1, in_ready1, res1}, {2'b10, 32'd7});
      chk("bp_hold_s4", {out_valid4, in_ready4, res4}, {2'b10, 32'd7});
      @(negedge CLK);
    end
    IN_VALID = 1'b0; OUT_READY = 1'b1;
    @(negedge CLK);
    OUT_READY = 1'b0;
    @(negedge CLK);
    chk("bp_no_ghost", {out_valid1, out_valid4, in_ready1, in_ready4}, 4'b0011);

    // Reset mid-EXEC of SLL by 20 after a non-zero result.
    run_op(mk(4'b0000, 32'd1, 32'd1, 32'd2, 0, 0, 1, 1));
    ALUSELECT = 4'b0011; OPA = 32'h1; OPB = 32'd20; IN_VALID = 1'b1;
    @(negedge CLK);
    IN_VALID = 1'b0;
    repeat (2) @(negedge CLK);
    chk("exec_busy", {out_valid1, in_ready1, out_valid4, in_ready4}, 4'b0000);
    #2 RST_n = 1'b0;
    #1;
    chk("reset_mid_exec", {out_valid1, res1, zero1, taken1}, '0);
    chk("reset_mid_exec_s4", {out_valid4, res4}, '0);
    @(negedge CLK);
    RST_n = 1'b1;
    repeat (25) @(negedge CLK);
    chk("ready_after_mid_reset", {in_ready1, in_ready4, out_valid1, out_valid4}, 4'b1100);

    for (int i = 0; i < 40; i++) begin
      logic [3:0]  s;
      logic [31:0] a, b;
      s = 4'($urandom_range(0, 15));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
      if (i % 5 == 0) b = a;
      run_op(model(s, a, b));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
